// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core
// load/store unit (m0) and the debug/DMA port (m1). Each transaction is a
// fixed GRANT(IDLE) -> ACCESS -> RESP sequence, one in flight at a time.
// Misaligned or out-of-range commands are flagged at grant time and never
// produce a dmem write.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration on
// contention; otherwise m0 has fixed priority over m1.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES  = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [1:0]            m0_size,
    input  logic                  m0_sign,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [1:0]            m1_size,
    input  logic                  m1_sign,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_size,
    output logic                  mem_sign,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int END_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    state_t                r_state;
    logic                  r_owner;      // 1 = current transaction belongs to m1
    logic                  r_we;
    logic                  r_err;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [1:0]            r_mem_size;
    logic                  r_mem_sign;
    logic                  r_m0_rvalid;
    logic [DATA_WIDTH-1:0] r_m0_rdata;
    logic                  r_m0_err;
    logic                  r_m1_rvalid;
    logic [DATA_WIDTH-1:0] r_m1_rdata;
    logic                  r_m1_err;
`ifdef DMEM_ARB_RR_EN
    logic                  r_prio_m1;    // 1 = m1 wins the next tie
`endif

    logic                  w_any;
    logic                  w_pick_m1;
    logic                  w_idle;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [1:0]            w_size;
    logic                  w_sign;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_resp_data;

    // Misalignment / range check; the end address is computed one bit wider
    // so that accesses near the top of the address space cannot wrap.
    function automatic logic f_access_err(input logic [ADDR_WIDTH-1:0] addr,
                                          input logic [1:0]            size);
        logic            v_mis;
        logic [END_W-1:0] v_end;
        case (size)
            2'b00: begin
                v_mis = 1'b0;
                v_end = {1'b0, addr} + END_W'(1);
            end
            2'b01: begin
                v_mis = addr[0];
                v_end = {1'b0, addr} + END_W'(2);
            end
            default: begin
                v_mis = (addr[1:0] != 2'b00);
                v_end = {1'b0, addr} + END_W'(4);
            end
        endcase
        return v_mis | (v_end > END_W'(MEM_BYTES));
    endfunction

    // Pick the winning requester for this IDLE cycle.
    always_comb begin
        w_any     = m0_req | m1_req;
        w_pick_m1 = 1'b0;
        if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
            w_pick_m1 = r_prio_m1;
`else
            w_pick_m1 = 1'b0;
`endif
        end else if (m1_req) begin
            w_pick_m1 = 1'b1;
        end else begin
            w_pick_m1 = 1'b0;
        end
    end

    // Route the winner's command toward the command latch.
    always_comb begin
        if (w_pick_m1) begin
            w_we    = m1_we;
            w_addr  = m1_addr;
            w_wdata = m1_wdata;
            w_size  = m1_size;
            w_sign  = m1_sign;
        end else begin
            w_we    = m0_we;
            w_addr  = m0_addr;
            w_wdata = m0_wdata;
            w_size  = m0_size;
            w_sign  = m0_sign;
        end
    end

    assign w_err       = f_access_err(w_addr, w_size);
    assign w_idle      = (r_state == ST_IDLE) & rst_n;
    assign m0_gnt      = w_idle & w_any & ~w_pick_m1;
    assign m1_gnt      = w_idle & w_any & w_pick_m1;
    assign w_resp_data = (~r_we & ~r_err) ? mem_rdata : {DATA_WIDTH{1'b0}};

    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_size    = r_mem_size;
    assign mem_sign    = r_mem_sign;
    assign m0_rvalid   = r_m0_rvalid;
    assign m0_rdata    = r_m0_rdata;
    assign m0_err      = r_m0_err;
    assign m1_rvalid   = r_m1_rvalid;
    assign m1_rdata    = r_m1_rdata;
    assign m1_err      = r_m1_err;

    // Transaction FSM with its registered dmem-side and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_WIDTH{1'b0}};
            r_mem_wdata <= {DATA_WIDTH{1'b0}};
            r_mem_size  <= 2'b00;
            r_mem_sign  <= 1'b0;
            r_m0_rvalid <= 1'b0;
            r_m0_rdata  <= {DATA_WIDTH{1'b0}};
            r_m0_err    <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m1_rdata  <= {DATA_WIDTH{1'b0}};
            r_m1_err    <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            r_prio_m1   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner     <= w_pick_m1;
                        r_we        <= w_we;
                        r_err       <= w_err;
                        r_mem_we    <= w_we & ~w_err;
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_wdata;
                        r_mem_size  <= w_size;
                        r_mem_sign  <= w_sign;
`ifdef DMEM_ARB_RR_EN
                        r_prio_m1   <= ~w_pick_m1;
`endif
                        r_state     <= ST_ACCESS;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    r_mem_we <= 1'b0;
                    if (r_owner) begin
                        r_m1_rvalid <= 1'b1;
                        r_m1_rdata  <= w_resp_data;
                        r_m1_err    <= r_err;
                    end else begin
                        r_m0_rvalid <= 1'b1;
                        r_m0_rdata  <= w_resp_data;
                        r_m0_err    <= r_err;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_m0_rvalid <= 1'b0;
                    r_m0_rdata  <= {DATA_WIDTH{1'b0}};
                    r_m0_err    <= 1'b0;
                    r_m1_rvalid <= 1'b0;
                    r_m1_rdata  <= {DATA_WIDTH{1'b0}};
                    r_m1_err    <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_mem_we    <= 1'b0;
                    r_m0_rvalid <= 1'b0;
                    r_m1_rvalid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: byte-array dmem model plus a reference memory
// and response rules computed from the access rules (size, alignment,
// range, little-endian sign/zero extension). Follows DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req, m0_we, m0_sign, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [1:0]  m0_size;
    logic        m1_req, m1_we, m1_sign, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [1:0]  m1_size;
    logic        mem_we, mem_sign;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;

    logic [7:0]  dmem    [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic        mem_clear;
    int          n_tests = 0;
    int          n_fail  = 0;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_size(m0_size), .m0_sign(m0_sign), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_size(m1_size), .m1_sign(m1_sign), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_sign(mem_sign), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // dmem model: synchronous little-endian write, cleared at start of run.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 4096; i++) dmem[i] <= 8'h00;
        end else if (mem_we) begin
            dmem[mem_addr[11:0]] <= mem_wdata[7:0];
            if (mem_size != 2'b00) dmem[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
            if (mem_size[1]) begin
                dmem[mem_addr[11:0] + 12'd2] <= mem_wdata[23:16];
                dmem[mem_addr[11:0] + 12'd3] <= mem_wdata[31:24];
            end
        end
    end

    // dmem model: combinational sized read with optional sign extension.
    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        b0 = dmem[mem_addr[11:0]];
        b1 = dmem[mem_addr[11:0] + 12'd1];
        b2 = dmem[mem_addr[11:0] + 12'd2];
        b3 = dmem[mem_addr[11:0] + 12'd3];
        case (mem_size)
            2'b00:   mem_rdata = {{24{mem_sign & b0[7]}}, b0};
            2'b01:   mem_rdata = {{16{mem_sign & b1[7]}}, b1, b0};
            default: mem_rdata = {b3, b2, b1, b0};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic exp_err(input logic [31:0] a, input logic [1:0] sz);
        longint last;
        if (sz == 2'b01 && a[0]) return 1'b1;
        if (sz[1] && a[1:0] != 2'b00) return 1'b1;
        last = longint'({32'h0, a}) + longint'(nbytes(sz));
        return last > 64'sd4096;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        logic [31:0] v;
        int nb;
        nb = nbytes(sz);
        v  = 32'h0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[int'(a[11:0]) + k];
        if (sg && nb == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
        if (sg && nb == 2 && v[15]) v[31:16] = 16'hFFFF;
        return v;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int k = 0; k < nbytes(sz); k++) ref_mem[int'(a[11:0]) + k] = d[8*k +: 8];
    endtask

    function automatic logic gnt_of(input int m);
        return (m == 0) ? m0_gnt : m1_gnt;
    endfunction
    function automatic logic rvalid_of(input int m);
        return (m == 0) ? m0_rvalid : m1_rvalid;
    endfunction
    function automatic logic err_of(input int m);
        return (m == 0) ? m0_err : m1_err;
    endfunction
    function automatic logic [31:0] rdata_of(input int m);
        return (m == 0) ? m0_rdata : m1_rdata;
    endfunction

    task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] sz, input logic sg);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_size = sz; m0_sign = sg;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_size = sz; m1_sign = sg;
        end
    endtask

    task automatic wait_gnt(input int m);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (!gnt_of(m) && cyc < 16) begin
            @(negedge clk);
            cyc++;
        end
        check("gnt", 32'(gnt_of(m)), 32'd1);
    endtask

    // One complete transaction with cycle-exact checks of the 3-cycle sequence.
    task automatic txn(input int m, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] sz, input logic sg);
        logic        e;
        logic [31:0] exp_rd;
        e      = exp_err(addr, sz);
        exp_rd = (!we && !e) ? exp_read(addr, sz, sg) : 32'h0;
        @(posedge clk); #1;
        drive(m, 1'b1, we, addr, wdata, sz, sg);
        wait_gnt(m);
        check("gnt_other", 32'(gnt_of(1 - m)), 32'd0);
        @(posedge clk); #1;
        drive(m, 1'b0, we, addr, wdata, sz, sg);
        @(negedge clk);
        check("access_we", 32'(mem_we), 32'(we & ~e));
        check("access_addr", mem_addr, addr);
        if (we) check("access_wdata", mem_wdata, wdata);
        check("access_no_rvalid", 32'(rvalid_of(m)), 32'd0);
        check("access_no_gnt", 32'(m0_gnt | m1_gnt), 32'd0);
        @(negedge clk);
        check("resp_rvalid", 32'(rvalid_of(m)), 32'd1);
        check("resp_other_rvalid", 32'(rvalid_of(1 - m)), 32'd0);
        check("resp_err", 32'(err_of(m)), 32'(e));
        check("resp_rdata", rdata_of(m), exp_rd);
        check("resp_mem_we", 32'(mem_we), 32'd0);
        if (we && !e) ref_write(addr, sz, wdata);
        @(negedge clk);
        check("rvalid_pulse", 32'(rvalid_of(m)), 32'd0);
        check("rdata_idle", rdata_of(m), 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, e0, e1;
        logic [1:0]  sz;
        logic        saw;
        int          got[$];
        int          exp_order[4];
        int          cyc, nresp;

        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        mem_clear = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_clear = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_gnt", 32'(m0_gnt | m1_gnt), 32'd0);
        check("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        check("rst_err", {30'd0, m1_err, m0_err}, 32'd0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_cmd", mem_addr | mem_wdata | {29'd0, mem_sign, mem_size}, 32'h0);
        rst_n = 1'b1;

        // write then read, sized reads
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        txn(0, 1'b1, 32'h20, 32'h80FF7F01, 2'b10, 1'b0);
        txn(1, 1'b0, 32'h21, 32'h0, 2'b00, 1'b1);
        txn(1, 1'b0, 32'h22, 32'h0, 2'b01, 1'b1);
        txn(1, 1'b0, 32'h20, 32'h0, 2'b00, 1'b0);
        txn(0, 1'b0, 32'h20, 32'h0, 2'b11, 1'b0);
        check("sized_ref", exp_read(32'h22, 2'b01, 1'b1), 32'hFFFF80FF);

        // error cases
        txn(0, 1'b1, 32'h31, 32'h1111, 2'b01, 1'b0);
        txn(0, 1'b0, 32'hFFE, 32'h0, 2'b10, 1'b0);
        txn(1, 1'b1, 32'h1000, 32'hCAFEF00D, 2'b10, 1'b0);
        txn(1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        txn(0, 1'b0, 32'hFFFFFFFE, 32'h0, 2'b01, 1'b0);
        txn(0, 1'b0, 32'hFFE, 32'h0, 2'b01, 1'b1);

        // randomized traffic
        for (int t = 0; t < 80; t++) begin
            sz = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                6, 7:    a = 32'd4088 + $urandom_range(0, 7);
                8:       a = 32'h1000 + $urandom_range(0, 255);
                9:       a = 32'hFFFFFFFC + $urandom_range(0, 3);
                default: a = $urandom_range(0, 63);
            endcase
            if ($urandom_range(0, 9) < 7) a = (sz == 2'b00) ? a : ((sz == 2'b01) ? {a[31:1], 1'b0} : {a[31:2], 2'b00});
            txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)));
        end

        // cancellation: m1 pulses req for one ACCESS cycle only
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        wait_gnt(0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        drive(1, 1'b1, 1'b1, 32'h10, 32'h55555555, 2'b10, 1'b0);
        @(negedge clk);
        check("cancel_gnt_access", 32'(m1_gnt), 32'd0);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b1, 32'h10, 32'h55555555, 2'b10, 1'b0);
        saw = 1'b0;
        nresp = 0;
        repeat (6) begin
            @(negedge clk);
            saw = saw | m1_gnt | m1_rvalid;
            if (m0_rvalid) nresp++;
        end
        check("cancel_m1_quiet", 32'(saw), 32'd0);
        check("cancel_m0_resp", 32'(nresp), 32'd1);
        txn(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);

        // reset during ACCESS of a write
        txn(0, 1'b1, 32'h40, 32'hA5A5A5A5, 2'b10, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h40, 32'h12345678, 2'b10, 1'b0);
        wait_gnt(0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 32'h40, 32'h12345678, 2'b10, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_mem_cmd", mem_addr | mem_wdata | {29'd0, mem_sign, mem_size}, 32'h0);
        check("midrst_resp", {28'd0, m1_err, m0_err, m1_rvalid, m0_rvalid}, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0);
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw = saw | m0_rvalid | m1_rvalid | m0_gnt | m1_gnt;
        end
        check("midrst_quiet", 32'(saw), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_gnt", 32'(m1_gnt), 32'd1);
        drive(1, 1'b0, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0);
        check("midrst_dmem", {dmem[12'h43], dmem[12'h42], dmem[12'h41], dmem[12'h40]}, 32'hA5A5A5A5);
        txn(1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0);

        // contention from a fresh reset
        do_reset();
`ifdef DMEM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        e0 = exp_read(32'h10, 2'b10, 1'b0);
        e1 = exp_read(32'h20, 2'b10, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
        cyc = 0;
        nresp = 0;
        while (got.size() < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (m0_gnt && m1_gnt) check("dual_gnt", 32'd1, 32'd0);
            if (m0_gnt) got.push_back(0);
            if (m1_gnt) got.push_back(1);
            if (m0_rvalid) begin nresp++; check("cont_rdata0", m0_rdata, e0); end
            if (m1_rvalid) begin nresp++; check("cont_rdata1", m1_rdata, e1); end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        drive(1, 1'b0, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
        repeat (3) begin
            @(negedge clk);
            if (m0_rvalid) begin nresp++; check("cont_rdata0", m0_rdata, e0); end
            if (m1_rvalid) begin nresp++; check("cont_rdata1", m1_rdata, e1); end
        end
        check("cont_grants", 32'(got.size()), 32'd4);
        check("cont_resps", 32'(nresp), 32'd4);
        for (int i = 0; i < got.size() && i < 4; i++) check("cont_order", 32'(got[i]), 32'(exp_order[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
